// File: rtl/rowwise_engine.sv
// Streams LANES-wide beats from two vector memories through a latched element-wise op.
// Optional clamping of ADD/SUB/MUL results (plus sticky sat_o) under ROWWISE_ENGINE_SAT_EN.
module rowwise_engine #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int LANES  = 4,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [2:0]                     op_i,
  input  logic                           bcast_i,
  input  logic [DATA_W-1:0]              scalar_i,
  input  logic [$clog2(DEPTH/LANES):0]   len_i,
  output logic                           rd_en_o,
  output logic [$clog2(DEPTH/LANES)-1:0] rd_addr_o,
  input  logic [LANES*DATA_W-1:0]        a_rdata_i,
  input  logic [LANES*DATA_W-1:0]        b_rdata_i,
  output logic                           wr_en_o,
  output logic [$clog2(DEPTH/LANES)-1:0] wr_addr_o,
  output logic [LANES*DATA_W-1:0]        wr_data_o,
  output logic                           busy_o,
  output logic                           done_o
`ifdef ROWWISE_ENGINE_SAT_EN
  ,
  output logic                           sat_o
`endif
);

  localparam int AW = $clog2(DEPTH/LANES);
  localparam int LW = AW + 1;
  localparam int WW = 2 * DATA_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_MAX  = 3'd3;
  localparam logic [2:0] OP_MIN  = 3'd4;
  localparam logic [2:0] OP_COPY = 3'd5;

  localparam logic signed [WW-1:0] MAX_V = {{(WW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [WW-1:0] MIN_V = ~MAX_V;

  logic [1:0]        state_q;
  logic [2:0]        op_q;
  logic              bcast_q;
  logic [DATA_W-1:0] scalar_q;
  logic [LW-1:0]     len_q;
  logic [AW-1:0]     rd_cnt_q;
  logic [RD_LAT-1:0] vld_q;
  logic [AW-1:0]     addr_q [RD_LAT];
  logic              accept;
  logic              last_rd;
  logic              arith;

  logic signed [DATA_W-1:0] a_l    [LANES];
  logic signed [DATA_W-1:0] b_l    [LANES];
  logic signed [WW-1:0]     a_w    [LANES];
  logic signed [WW-1:0]     b_w    [LANES];
  logic signed [WW-1:0]     full_l [LANES];
  logic [LANES-1:0]         clamp_l;
  logic [LANES*DATA_W-1:0]  res;

  assign in_ready_o = (state_q == S_IDLE);
  assign busy_o     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done_o     = (state_q == S_DONE);
  assign rd_en_o    = (state_q == S_ISSUE);
  assign rd_addr_o  = rd_cnt_q;
  assign accept     = in_valid_i && in_ready_o;
  assign last_rd    = rd_en_o && (({1'b0, rd_cnt_q} + LW'(1)) == len_q);
  assign arith      = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_MUL);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      bcast_q  <= 1'b0;
      scalar_q <= '0;
      len_q    <= '0;
      rd_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q     <= op_i;
            bcast_q  <= bcast_i;
            scalar_q <= scalar_i;
            len_q    <= len_i;
            rd_cnt_q <= '0;
            state_q  <= (len_i == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          rd_cnt_q <= rd_cnt_q + AW'(1);
          if (last_rd) state_q <= S_DRAIN;
        end
        // Last write is on the bus and nothing is left behind it in the pipeline.
        S_DRAIN: if (wr_en_o && !(|vld_q)) state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    res     = '0;
    clamp_l = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      a_l[l] = a_rdata_i[l*DATA_W +: DATA_W];
      b_l[l] = bcast_q ? scalar_q : b_rdata_i[l*DATA_W +: DATA_W];
      a_w[l] = {{(WW-DATA_W){a_l[l][DATA_W-1]}}, a_l[l]};
      b_w[l] = {{(WW-DATA_W){b_l[l][DATA_W-1]}}, b_l[l]};
      case (op_q)
        OP_ADD:  full_l[l] = a_w[l] + b_w[l];
        OP_SUB:  full_l[l] = a_w[l] - b_w[l];
        OP_MUL:  full_l[l] = (a_w[l] * b_w[l]) >>> FRAC_W;
        OP_MAX:  full_l[l] = (a_l[l] > b_l[l]) ? a_w[l] : b_w[l];
        OP_MIN:  full_l[l] = (a_l[l] < b_l[l]) ? a_w[l] : b_w[l];
        OP_COPY: full_l[l] = a_w[l];
        default: full_l[l] = '0;
      endcase
      clamp_l[l] = arith && ((full_l[l] > MAX_V) || (full_l[l] < MIN_V));
`ifdef ROWWISE_ENGINE_SAT_EN
      if (clamp_l[l])
        res[l*DATA_W +: DATA_W] = (full_l[l] > MAX_V) ? MAX_V[DATA_W-1:0] : MIN_V[DATA_W-1:0];
      else
        res[l*DATA_W +: DATA_W] = full_l[l][DATA_W-1:0];
`else
      res[l*DATA_W +: DATA_W] = full_l[l][DATA_W-1:0];
`endif
    end
  end

  // Valid/address shift register covers the memory latency; the output register is the last stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q     <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) addr_q[i] <= '0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      vld_q[0]  <= rd_en_o;
      addr_q[0] <= rd_cnt_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
      wr_en_o <= vld_q[RD_LAT-1];
      if (vld_q[RD_LAT-1]) begin
        wr_addr_o <= addr_q[RD_LAT-1];
        wr_data_o <= res;
      end
    end
  end

`ifdef ROWWISE_ENGINE_SAT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                 sat_o <= 1'b0;
    else if (accept)                           sat_o <= 1'b0;
    else if (vld_q[RD_LAT-1] && (|clamp_l))    sat_o <= 1'b1;
  end
`else
  logic unused_clamp;
  assign unused_clamp = |clamp_l;
`endif

endmodule

// File: tb/tb_rowwise_engine.sv
// Directed + randomized bench for rowwise_engine; two instances (RD_LAT=1 and RD_LAT=3)
// run side by side against a behavioural element model and cycle-exact timing rules.
module tb_rowwise_engine;

  localparam int DW = 16;
  localparam int FW = 8;
  localparam int LN = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic [2:0]  op_i;
  logic        bcast_i;
  logic [15:0] scalar_i;
  logic [2:0]  len_i;

  logic        r1_ready, r1_rd_en, r1_wr_en, r1_busy, r1_done;
  logic [1:0]  r1_rd_addr, r1_wr_addr;
  logic [63:0] r1_wr_data, a1_rdata, b1_rdata;
  logic        r3_ready, r3_rd_en, r3_wr_en, r3_busy, r3_done;
  logic [1:0]  r3_rd_addr, r3_wr_addr;
  logic [63:0] r3_wr_data, a3_rdata, b3_rdata;
`ifdef ROWWISE_ENGINE_SAT_EN
  logic        r1_sat, r3_sat;
`endif

  logic [15:0] ma [16];
  logic [15:0] mb [16];
  logic        b_x = 1'b0;
  logic [63:0] pa [3];
  logic [63:0] pb [3];
  logic [63:0] o1 [4];
  logic [63:0] o3 [4];
  logic [63:0] exp_beat [4];
  logic        exp_sat;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  rowwise_engine #(.DATA_W(DW), .FRAC_W(FW), .LANES(LN), .DEPTH(16), .RD_LAT(1)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(r1_ready),
    .op_i(op_i), .bcast_i(bcast_i), .scalar_i(scalar_i), .len_i(len_i),
    .rd_en_o(r1_rd_en), .rd_addr_o(r1_rd_addr), .a_rdata_i(a1_rdata), .b_rdata_i(b1_rdata),
    .wr_en_o(r1_wr_en), .wr_addr_o(r1_wr_addr), .wr_data_o(r1_wr_data),
    .busy_o(r1_busy), .done_o(r1_done)
`ifdef ROWWISE_ENGINE_SAT_EN
    , .sat_o(r1_sat)
`endif
  );

  rowwise_engine #(.DATA_W(DW), .FRAC_W(FW), .LANES(LN), .DEPTH(16), .RD_LAT(3)) u_dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(r3_ready),
    .op_i(op_i), .bcast_i(bcast_i), .scalar_i(scalar_i), .len_i(len_i),
    .rd_en_o(r3_rd_en), .rd_addr_o(r3_rd_addr), .a_rdata_i(a3_rdata), .b_rdata_i(b3_rdata),
    .wr_en_o(r3_wr_en), .wr_addr_o(r3_wr_addr), .wr_data_o(r3_wr_data),
    .busy_o(r3_busy), .done_o(r3_done)
`ifdef ROWWISE_ENGINE_SAT_EN
    , .sat_o(r3_sat)
`endif
  );

  function automatic logic [63:0] beat_a(input logic [1:0] ad);
    return {ma[ad*4+3], ma[ad*4+2], ma[ad*4+1], ma[ad*4]};
  endfunction

  function automatic logic [63:0] beat_b(input logic [1:0] ad);
    return {mb[ad*4+3], mb[ad*4+2], mb[ad*4+1], mb[ad*4]};
  endfunction

  // Synchronous-read memories: 1-cycle for the first instance, 3-cycle for the second.
  always @(posedge clk_i) begin
    a1_rdata <= beat_a(r1_rd_addr);
    b1_rdata <= b_x ? 64'hx : beat_b(r1_rd_addr);
    pa[0] <= beat_a(r3_rd_addr);
    pb[0] <= b_x ? 64'hx : beat_b(r3_rd_addr);
    pa[1] <= pa[0];
    pb[1] <= pb[0];
    pa[2] <= pa[1];
    pb[2] <= pb[1];
    if (r1_wr_en) o1[r1_wr_addr] <= r1_wr_data;
    if (r3_wr_en) o3[r3_wr_addr] <= r3_wr_data;
  end
  assign a3_rdata = pa[2];
  assign b3_rdata = pb[2];

  // Element result from the arithmetic rules; bit 16 flags a clamp.
  function automatic logic [16:0] ref_elem(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int ai, bi, p, r;
    bit cl;
    ai = int'($signed(a));
    bi = int'($signed(b));
    r  = 0;
    cl = 1'b0;
    case (op)
      3'd0: r = ai + bi;
      3'd1: r = ai - bi;
      3'd2: begin
        p = ai * bi;
        r = (p >= 0) ? p / (1 << FW) : -((-p + (1 << FW) - 1) / (1 << FW));
      end
      3'd3: r = (ai > bi) ? ai : bi;
      3'd4: r = (ai < bi) ? ai : bi;
      3'd5: r = ai;
      default: r = 0;
    endcase
`ifdef ROWWISE_ENGINE_SAT_EN
    if (op <= 3'd2) begin
      if (r > 32767) begin r = 32767; cl = 1'b1; end
      else if (r < -32768) begin r = -32768; cl = 1'b1; end
    end
`endif
    return {cl, r[15:0]};
  endfunction

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_cycle(input int L, input int c, input int len,
                           input logic rd_en, input logic [1:0] rd_addr,
                           input logic wr_en, input logic [1:0] wr_addr, input logic [63:0] wr_data,
                           input logic busy, input logic done, input logic ready);
    bit e_rd, e_wr, e_done, e_busy;
    string t;
    e_rd   = (len > 0) && (c <= len);
    e_wr   = (len > 0) && (c >= L + 2) && (c <= len + L + 1);
    e_done = (len == 0) ? (c == 1) : (c == len + L + 2);
    e_busy = (len > 0) && (c <= len + L + 1);
    t = $sformatf("lat%0d cyc%0d", L, c);
    cmp({t, " rd_en"}, 64'(rd_en), 64'(e_rd));
    if (e_rd) cmp({t, " rd_addr"}, 64'(rd_addr), 64'(c - 1));
    cmp({t, " wr_en"}, 64'(wr_en), 64'(e_wr));
    if (e_wr) begin
      cmp({t, " wr_addr"}, 64'(wr_addr), 64'(c - L - 2));
      cmp({t, " wr_data"}, wr_data, exp_beat[c - L - 2]);
    end
    cmp({t, " busy"}, 64'(busy), 64'(e_busy));
    cmp({t, " done"}, 64'(done), 64'(e_done));
    cmp({t, " ready"}, 64'(ready), 64'(!(e_busy || e_done)));
  endtask

  task automatic fill(input logic [15:0] a, input logic [15:0] b, input bit rnd);
    for (int i = 0; i < 16; i++) begin
      ma[i] = rnd ? 16'($urandom) : a;
      mb[i] = rnd ? 16'($urandom) : b;
    end
  endtask

  // Start at cycle 0, then check every cycle until both instances are idle again.
  // With noise, the op/scalar/len inputs churn and in_valid is pulsed while neither engine is idle.
  task automatic run_op(input logic [2:0] op, input logic bc, input logic [15:0] sc,
                        input int len, input bit noise);
    logic [16:0] e;
    int lastv;
    exp_sat = 1'b0;
    for (int i = 0; i < len; i++) begin
      for (int l = 0; l < LN; l++) begin
        e = ref_elem(op, ma[i*4+l], bc ? sc : mb[i*4+l]);
        exp_beat[i][l*16 +: 16] = e[15:0];
        if (e[16]) exp_sat = 1'b1;
      end
    end
    @(posedge clk_i); #1;
    in_valid_i = 1'b1;
    op_i       = op;
    bcast_i    = bc;
    scalar_i   = sc;
    len_i      = 3'(len);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    lastv = (len == 0) ? 1 : len + 3;
    for (int c = 1; c <= len + 6; c++) begin
      chk_cycle(1, c, len, r1_rd_en, r1_rd_addr, r1_wr_en, r1_wr_addr, r1_wr_data, r1_busy, r1_done, r1_ready);
      chk_cycle(3, c, len, r3_rd_en, r3_rd_addr, r3_wr_en, r3_wr_addr, r3_wr_data, r3_busy, r3_done, r3_ready);
      if (noise) begin
        op_i       = 3'($urandom);
        bcast_i    = 1'($urandom);
        scalar_i   = 16'($urandom);
        len_i      = 3'($urandom_range(1, 4));
        in_valid_i = (c <= lastv) ? 1'($urandom) : 1'b0;
      end
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0;
`ifdef ROWWISE_ENGINE_SAT_EN
    cmp("sat lat1", 64'(r1_sat), 64'(exp_sat));
    cmp("sat lat3", 64'(r3_sat), 64'(exp_sat));
`endif
  endtask

  task automatic chk_quiet(input string t);
    cmp({t, " rd_en1"}, 64'(r1_rd_en), 64'd0);
    cmp({t, " wr_en1"}, 64'(r1_wr_en), 64'd0);
    cmp({t, " busy1"},  64'(r1_busy),  64'd0);
    cmp({t, " done1"},  64'(r1_done),  64'd0);
    cmp({t, " ready1"}, 64'(r1_ready), 64'd1);
    cmp({t, " rd_en3"}, 64'(r3_rd_en), 64'd0);
    cmp({t, " wr_en3"}, 64'(r3_wr_en), 64'd0);
    cmp({t, " busy3"},  64'(r3_busy),  64'd0);
    cmp({t, " done3"},  64'(r3_done),  64'd0);
    cmp({t, " ready3"}, 64'(r3_ready), 64'd1);
  endtask

  initial begin
    rst_i      = 1'b1;
    in_valid_i = 1'b0;
    op_i       = '0;
    bcast_i    = 1'b0;
    scalar_i   = '0;
    len_i      = '0;
    fill(16'h0, 16'h0, 1'b0);
    @(posedge clk_i); #1;
    chk_quiet("reset");
    cmp("reset wr_data1", r1_wr_data, 64'd0);
    cmp("reset wr_addr3", 64'(r3_wr_addr), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    fill(16'h0100, 16'h0200, 1'b0);
    run_op(3'd0, 1'b0, 16'h0, 4, 1'b0);
    cmp("add out1", o1[3], {4{16'h0300}});
    cmp("add out3", o3[0], {4{16'h0300}});

    fill(16'h0180, 16'hFF00, 1'b0);
    run_op(3'd2, 1'b0, 16'h0, 4, 1'b0);
    cmp("mul out1", o1[1], {4{16'hFE80}});
    run_op(3'd3, 1'b0, 16'h0, 4, 1'b0);
    cmp("max out1", o1[2], {4{16'h0180}});
    run_op(3'd4, 1'b0, 16'h0, 4, 1'b0);
    cmp("min out3", o3[3], {4{16'hFF00}});

    fill(16'h7F00, 16'h0200, 1'b0);
    run_op(3'd0, 1'b0, 16'h0, 2, 1'b0);
`ifdef ROWWISE_ENGINE_SAT_EN
    cmp("addsat out1", o1[0], {4{16'h7FFF}});
    cmp("addsat flag", 64'(r1_sat), 64'd1);
`else
    cmp("addwrap out1", o1[0], {4{16'h8100}});
`endif

    fill(16'h0000, 16'h1234, 1'b0);
    b_x = 1'b1;
    run_op(3'd1, 1'b1, 16'h0100, 4, 1'b1);
    b_x = 1'b0;
    cmp("bcast sub out1", o1[2], {4{16'hFF00}});
    cmp("bcast sub out3", o3[1], {4{16'hFF00}});

    run_op(3'd0, 1'b0, 16'h0, 0, 1'b1);
    fill(16'h0, 16'h0, 1'b1);
    run_op(3'd6, 1'b0, 16'h0, 3, 1'b1);
    cmp("reserved out1", o1[0], 64'd0);

    for (int k = 0; k < 24; k++) begin
      fill(16'h0, 16'h0, 1'b1);
      run_op(3'($urandom_range(0, 7)), 1'($urandom), 16'($urandom),
             int'($urandom_range(0, 4)), 1'($urandom));
    end

    // Asynchronous reset in the middle of a run.
    fill(16'h0, 16'h0, 1'b1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b1;
    op_i       = 3'd0;
    bcast_i    = 1'b0;
    len_i      = 3'd4;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    cmp("pre-rst wr_en1", 64'(r1_wr_en), 64'd1);
    cmp("pre-rst busy3", 64'(r3_busy), 64'd1);
    #2 rst_i = 1'b1;
    #1 chk_quiet("midrst");
    cmp("midrst wr_data1", r1_wr_data, 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
      chk_quiet($sformatf("postrst%0d", i));
    end
    fill(16'h0, 16'h0, 1'b1);
    run_op(3'd0, 1'b0, 16'h0, 4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
